// File: rtl/nbit_mosi_spi_sequencer_pkg.sv
// Shared types and helpers for the multi-byte MOSI sequencer and its byte selector.
package nbit_mosi_spi_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

  // Maps logical byte index to its physical slot inside the packed data word.
  function automatic int byte_slot(input int idx, input int depth, input int order);
    return (order == ORDER_MSB_FIRST) ? depth - 1 - idx : idx;
  endfunction

endpackage

// File: rtl/nbit_mosi_spi_sequencer_byte_mux.sv
// Combinational byte + D/C selector over a packed multi-byte word, honouring byte order.
module nbit_mosi_spi_sequencer_byte_mux
  import nbit_mosi_spi_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int BYTE_ORDER = ORDER_LSB_FIRST,
  parameter int IDX_W      = 4
) (
  input  logic [WIDTH*DEPTH-1:0] data,
  input  logic [DEPTH-1:0]       dc,
  input  logic [IDX_W-1:0]       idx,
  output logic [WIDTH-1:0]       byte_sel,
  output logic                   dc_sel
);

  // Out-of-range indices yield zero rather than wrapping.
  always_comb begin
    byte_sel = '0;
    dc_sel   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (idx == IDX_W'(k)) begin
        byte_sel = data[byte_slot(k, DEPTH, BYTE_ORDER)*WIDTH +: WIDTH];
        dc_sel   = dc[k];
      end
    end
  end

endmodule

// File: rtl/nbit_mosi_spi_sequencer.sv
// Multi-byte MOSI sequencer: shadows a packed transfer and feeds it byte by byte to the
// SPI byte transmitter with optional inter-byte gap, abort and completion status.
module nbit_mosi_spi_sequencer
  import nbit_mosi_spi_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int GAP_W      = 4,
  parameter int BYTE_ORDER = ORDER_LSB_FIRST,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   i_SCK,
  input  logic                   i_RST,
  input  logic                   i_START,
  input  logic                   i_ABORT,
  input  logic [WIDTH*DEPTH-1:0] i_DATA,
  input  logic [DEPTH-1:0]       i_DC,
  input  logic [CNT_W-1:0]       i_N_transmit,
  input  logic [GAP_W-1:0]       i_GAP,
  input  logic                   i_TX_DONE,
  output logic [WIDTH-1:0]       o_DATA,
  output logic                   o_START,
  output logic                   o_DC,
  output logic                   o_MOSI_FINAL_BYTE,
  output logic                   o_BUSY,
  output logic                   o_DONE,
  output logic [CNT_W-1:0]       o_COUNT
);

  seq_state_t             state;
  logic [WIDTH*DEPTH-1:0] data_sh;
  logic [DEPTH-1:0]       dc_sh;
  logic [CNT_W-1:0]       n_sh;
  logic [CNT_W-1:0]       idx;
  logic [GAP_W-1:0]       gap_sh;
  logic [GAP_W-1:0]       gap_cnt;

  logic [CNT_W-1:0]       n_req;
  logic [CNT_W-1:0]       mux_idx;
  logic [CNT_W-1:0]       last_idx;
  logic [WIDTH*DEPTH-1:0] mux_data;
  logic [DEPTH-1:0]       mux_dc;
  logic                   mux_final;
  logic [WIDTH-1:0]       byte_sel;
  logic                   dc_sel;

  // The mux looks at the byte that will be loaded on the next edge, so the registered
  // outputs are valid in the same cycle o_START is high (live inputs when accepting).
  always_comb begin
    n_req    = (i_N_transmit > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_N_transmit;
    mux_data = (state == ST_IDLE) ? i_DATA : data_sh;
    mux_dc   = (state == ST_IDLE) ? i_DC : dc_sh;
    case (state)
      ST_IDLE:    mux_idx = '0;
      ST_WAIT_TX: mux_idx = idx + CNT_W'(1);
      default:    mux_idx = idx;
    endcase
    last_idx  = ((state == ST_IDLE) ? n_req : n_sh) - CNT_W'(1);
    mux_final = (mux_idx == last_idx);
  end

  nbit_mosi_spi_sequencer_byte_mux #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .BYTE_ORDER(BYTE_ORDER),
    .IDX_W     (CNT_W)
  ) u_byte_mux (
    .data    (mux_data),
    .dc      (mux_dc),
    .idx     (mux_idx),
    .byte_sel(byte_sel),
    .dc_sel  (dc_sel)
  );

  always_ff @(posedge i_SCK or posedge i_RST) begin
    if (i_RST) begin
      state             <= ST_IDLE;
      data_sh           <= '0;
      dc_sh             <= '0;
      n_sh              <= '0;
      idx               <= '0;
      gap_sh            <= '0;
      gap_cnt           <= '0;
      o_DATA            <= '0;
      o_START           <= 1'b0;
      o_DC              <= 1'b0;
      o_MOSI_FINAL_BYTE <= 1'b0;
      o_BUSY            <= 1'b0;
      o_DONE            <= 1'b0;
      o_COUNT           <= '0;
    end else begin
      o_START <= 1'b0;
      o_DONE  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_START && (n_req != '0)) begin
            data_sh           <= i_DATA;
            dc_sh             <= i_DC;
            n_sh              <= n_req;
            gap_sh            <= i_GAP;
            idx               <= '0;
            o_COUNT           <= '0;
            o_BUSY            <= 1'b1;
            o_START           <= 1'b1;
            o_DATA            <= byte_sel;
            o_DC              <= dc_sel;
            o_MOSI_FINAL_BYTE <= mux_final;
            state             <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_ABORT) begin
            o_BUSY            <= 1'b0;
            o_MOSI_FINAL_BYTE <= 1'b0;
            state             <= ST_IDLE;
          end else begin
            state <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          // Abort wins over a coincident completion: the byte is not counted.
          if (i_ABORT) begin
            o_BUSY            <= 1'b0;
            o_MOSI_FINAL_BYTE <= 1'b0;
            state             <= ST_IDLE;
          end else if (i_TX_DONE) begin
            o_COUNT <= o_COUNT + CNT_W'(1);
            if (idx == n_sh - CNT_W'(1)) begin
              o_DONE            <= 1'b1;
              o_BUSY            <= 1'b0;
              o_MOSI_FINAL_BYTE <= 1'b0;
              state             <= ST_DONE;
            end else begin
              idx <= idx + CNT_W'(1);
              if (gap_sh == '0) begin
                o_START           <= 1'b1;
                o_DATA            <= byte_sel;
                o_DC              <= dc_sel;
                o_MOSI_FINAL_BYTE <= mux_final;
                state             <= ST_LOAD;
              end else begin
                gap_cnt <= gap_sh;
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (i_ABORT) begin
            o_BUSY            <= 1'b0;
            o_MOSI_FINAL_BYTE <= 1'b0;
            state             <= ST_IDLE;
          end else if (gap_cnt == GAP_W'(1)) begin
            o_START           <= 1'b1;
            o_DATA            <= byte_sel;
            o_DC              <= dc_sel;
            o_MOSI_FINAL_BYTE <= mux_final;
            state             <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
